// File: rtl/nib_pkg.sv
// Shared types for the nibble deserializer: nibble width, nibble type and FSM states.
package nib_pkg;
    localparam int NIB_W = 4;
    typedef logic [NIB_W-1:0] nib_t;
    typedef enum logic {IDLE, COLLECT} des_state_e;
endpackage

// File: rtl/nib_fifo.sv
// Synchronous nibble FIFO; a push into a full FIFO is accepted only when a pop frees a slot that same cycle.
module nib_fifo
    import nib_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  nib_t push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output nib_t head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    nib_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit tells full apart from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/nibble_deserializer.sv
// Framed serial-to-nibble front end: assembles 4-bit nibbles, buffers them and
// presents them on a valid/ready port, with sticky error flags and a nibble counter.
module nibble_deserializer
    import nib_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_sof,
    input  logic             clear,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [3:0]       m_data,
    output logic             overflow,
    output logic             frag,
    output logic [CNT_W-1:0] nib_count
);
    des_state_e state;
    logic [1:0] bit_cnt;
    nib_t       shreg;
    logic [1:0] slot;
    logic [1:0] first_slot;
    logic       push_req;
    nib_t       push_data;
    logic       full;
    logic       empty;
    logic       pop;
    logic       accepted;
    logic       dropped;
    logic       frag_set;

    // Bit position within the nibble, mirrored for MSB-first streams.
    assign slot       = (MSB_FIRST != 0) ? ~bit_cnt : bit_cnt;
    assign first_slot = (MSB_FIRST != 0) ? 2'd3 : 2'd0;

    always_comb begin
        push_req  = 1'b0;
        push_data = shreg;
        if (state == COLLECT && s_valid && !s_sof && bit_cnt == 2'd3) begin
            push_req        = 1'b1;
            push_data[slot] = s_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 2'd0;
            shreg   <= '0;
        end else if (s_valid) begin
            case (state)
                IDLE: begin
                    if (s_sof) begin
                        shreg             <= '0;
                        shreg[first_slot] <= s_bit;
                        bit_cnt           <= 2'd1;
                        state             <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A start-of-frame always restarts assembly with this bit as bit 0.
                    if (s_sof) begin
                        shreg             <= '0;
                        shreg[first_slot] <= s_bit;
                        bit_cnt           <= 2'd1;
                    end else if (bit_cnt == 2'd3) begin
                        shreg   <= '0;
                        bit_cnt <= 2'd0;
                    end else begin
                        shreg[slot] <= s_bit;
                        bit_cnt     <= bit_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_valid  = !empty;
    assign pop      = m_valid && m_ready;
    assign accepted = push_req && (!full || pop);
    assign dropped  = push_req && full && !pop;
    assign frag_set = (state == COLLECT) && s_valid && s_sof && (bit_cnt != 2'd0);

    nib_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (m_data)
    );

    // clear wins over any same-cycle flag set or count increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frag      <= 1'b0;
            nib_count <= '0;
        end else if (clear) begin
            overflow  <= 1'b0;
            frag      <= 1'b0;
            nib_count <= '0;
        end else begin
            if (dropped)  overflow  <= 1'b1;
            if (frag_set) frag      <= 1'b1;
            if (accepted) nib_count <= nib_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_nibble_deserializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// compared every cycle against a bit-list/queue reference model.
module tb_nibble_deserializer;
    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_bit, s_sof, clear, m_ready;
    logic       m_valid_l, m_valid_m, overflow_l, overflow_m, frag_l, frag_m;
    logic [3:0] m_data_l, m_data_m;
    logic [7:0] nib_count_l, nib_count_m;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         started;
    bit         bits[$];
    logic [3:0] q_lsb[$];
    logic [3:0] q_msb[$];
    bit         exp_ovf, exp_frag;
    int         exp_cnt;

    always #5 clk = ~clk;

    nibble_deserializer #(.DEPTH(2), .MSB_FIRST(0), .CNT_W(8)) dut_lsb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
        .clear(clear), .m_valid(m_valid_l), .m_ready(m_ready), .m_data(m_data_l),
        .overflow(overflow_l), .frag(frag_l), .nib_count(nib_count_l)
    );

    nibble_deserializer #(.DEPTH(2), .MSB_FIRST(1), .CNT_W(8)) dut_msb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
        .clear(clear), .m_valid(m_valid_m), .m_ready(m_ready), .m_data(m_data_m),
        .overflow(overflow_m), .frag(frag_m), .nib_count(nib_count_m)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        started  = 1'b0;
        bits.delete();
        q_lsb.delete();
        q_msb.delete();
        exp_ovf  = 1'b0;
        exp_frag = 1'b0;
        exp_cnt  = 0;
    endtask

    // One clock of the reference model, using the inputs sampled at this edge.
    task automatic modelStep(input bit v, input bit b, input bit sof, input bit rdy, input bit clr);
        bit         do_pop, do_push, set_ovf, set_frag, ok;
        logic [3:0] nl, nm;
        do_pop  = rdy && (q_lsb.size() > 0);
        do_push = 1'b0; set_ovf = 1'b0; set_frag = 1'b0; ok = 1'b0;
        nl = 4'h0; nm = 4'h0;
        if (v && (started || sof)) begin
            started = 1'b1;
            if (sof) begin
                if (bits.size() != 0) set_frag = 1'b1;
                bits.delete();
            end
            bits.push_back(b);
            if (bits.size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    nl[i]     = bits[i];
                    nm[3 - i] = bits[i];
                end
                do_push = 1'b1;
                bits.delete();
            end
        end
        if (do_pop) begin
            void'(q_lsb.pop_front());
            void'(q_msb.pop_front());
        end
        if (do_push) begin
            if (q_lsb.size() < 2) begin
                q_lsb.push_back(nl);
                q_msb.push_back(nm);
                ok = 1'b1;
            end else begin
                set_ovf = 1'b1;
            end
        end
        if (clr) begin
            exp_ovf = 1'b0; exp_frag = 1'b0; exp_cnt = 0;
        end else begin
            if (set_ovf)  exp_ovf  = 1'b1;
            if (set_frag) exp_frag = 1'b1;
            if (ok)       exp_cnt  = (exp_cnt + 1) % 256;
        end
    endtask

    task automatic checkAll(input string tag);
        logic [3:0] el, em;
        el = (q_lsb.size() > 0) ? q_lsb[0] : 4'h0;
        em = (q_msb.size() > 0) ? q_msb[0] : 4'h0;
        checkOutput({tag, "_mvalid_l"}, 32'(m_valid_l), 32'(q_lsb.size() > 0));
        checkOutput({tag, "_mvalid_m"}, 32'(m_valid_m), 32'(q_msb.size() > 0));
        checkOutput({tag, "_mdata_l"}, 32'(m_data_l), 32'(el));
        checkOutput({tag, "_mdata_m"}, 32'(m_data_m), 32'(em));
        checkOutput({tag, "_ovf"}, 32'(overflow_l), 32'(exp_ovf));
        checkOutput({tag, "_ovf_m"}, 32'(overflow_m), 32'(exp_ovf));
        checkOutput({tag, "_frag"}, 32'(frag_l), 32'(exp_frag));
        checkOutput({tag, "_frag_m"}, 32'(frag_m), 32'(exp_frag));
        checkOutput({tag, "_cnt"}, 32'(nib_count_l), 32'(exp_cnt));
        checkOutput({tag, "_cnt_m"}, 32'(nib_count_m), 32'(exp_cnt));
    endtask

    task automatic applyStimulus(input string tag, input bit v, input bit b, input bit sof,
                                 input bit rdy, input bit clr);
        @(negedge clk);
        s_valid = v; s_bit = b; s_sof = sof; m_ready = rdy; clear = clr;
        @(posedge clk);
        modelStep(v, b, sof, rdy, clr);
        #1;
        checkAll(tag);
    endtask

    task automatic sendNibble(input string tag, input bit sof, input logic [3:0] seq, input logic [3:0] rdy);
        for (int i = 3; i >= 0; i--)
            applyStimulus(tag, 1'b1, seq[i], (i == 3) ? sof : 1'b0, rdy[i], 1'b0);
    endtask

    task automatic pulseReset(input string tag);
        @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b0; clear = 1'b0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll(tag);
        checkOutput({tag, "_mvalid0"}, 32'(m_valid_l), 32'd0);
        checkOutput({tag, "_mdata0"}, 32'(m_data_l), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0; clear = 1'b0; m_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst = 1'b0;

        // Test 1: LSB-first 1,0,1,1 -> 4'hD
        sendNibble("t1", 1'b1, 4'b1011, 4'b1111);
        checkOutput("t1_data", 32'(m_data_l), 32'h0D);
        checkOutput("t1_data_msb", 32'(m_data_m), 32'h0B);
        checkOutput("t1_cnt", 32'(nib_count_l), 32'd1);
        applyStimulus("t1_pop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("t2_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Test 2: back-to-back nibbles, then overflow on a full buffer
        sendNibble("t2a", 1'b1, 4'b1100, 4'b0000);
        sendNibble("t2b", 1'b0, 4'b0111, 4'b0000);
        checkOutput("t2_data3", 32'(m_data_l), 32'h3);
        sendNibble("t2c", 1'b0, 4'b1111, 4'b0000);
        checkOutput("t2_ovf", 32'(overflow_l), 32'd1);
        checkOutput("t2_cnt", 32'(nib_count_l), 32'd2);
        applyStimulus("t2_pop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_dataE", 32'(m_data_l), 32'hE);

        // Test 3: full buffer, simultaneous pop and push
        applyStimulus("t3_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sendNibble("t3a", 1'b0, 4'b0001, 4'b0000);
        sendNibble("t3b", 1'b0, 4'b1010, 4'b0001);
        checkOutput("t3_ovf", 32'(overflow_l), 32'd0);
        checkOutput("t3_cnt", 32'(nib_count_l), 32'd2);
        checkOutput("t3_data", 32'(m_data_l), 32'h8);

        // Test 4: fragment, then clear colliding with a push
        applyStimulus("t4_pop1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("t4_pop2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("t4_p0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("t4_p1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendNibble("t4n", 1'b1, 4'b0110, 4'b0000);
        checkOutput("t4_frag", 32'(frag_l), 32'd1);
        checkOutput("t4_data", 32'(m_data_l), 32'h6);
        applyStimulus("t4_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("t4_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("t4_c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("t4_c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_clr_frag", 32'(frag_l), 32'd0);
        checkOutput("t4_clr_cnt", 32'(nib_count_l), 32'd0);

        // Test 6: reset mid-nibble with data buffered
        applyStimulus("t6_p0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("t6_p1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pulseReset("t6_rst");

        // Test 5: bits before sof ignored; MSB-first 1,0,0,0 -> 4'h8
        applyStimulus("t5_i0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("t5_i1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("t5_i2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_idle", 32'(m_valid_l), 32'd0);
        sendNibble("t5", 1'b1, 4'b1000, 4'b0000);
        checkOutput("t5_msb", 32'(m_data_m), 32'h8);
        checkOutput("t5_lsb", 32'(m_data_l), 32'h1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0)
                pulseReset("rnd_rst");
            else
                applyStimulus("rnd", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                              $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                              $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
